// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// Extracts I/S/B/J/U/Z immediates, extends them to XLEN bits and registers the
// result behind a valid/ready handshake backed by a 2-entry skid buffer
// (output register OR plus skid register SK).
// Optional feature macro: IMM_GEN_PIPE_ERR_EN adds out_err, set for reserved types.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter int AUTO_SEL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
`ifdef IMM_GEN_PIPE_ERR_EN
    output logic             out_err,
`endif
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        T_I = 3'd0,
        T_S = 3'd1,
        T_B = 3'd2,
        T_J = 3'd3,
        T_U = 3'd4,
        T_Z = 3'd5,
        T_R = 3'd6
    } imm_type_e;

    imm_type_e        auto_type;
    imm_type_e        man_type;
    imm_type_e        sel_type;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  new_imm;
    logic             new_err;

    logic             or_valid;
    logic [XLEN-1:0]  or_imm;
    logic [TAG_W-1:0] or_tag;
    logic             sk_valid;
    logic [XLEN-1:0]  sk_imm;
    logic [TAG_W-1:0] sk_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
    logic             or_err;
    logic             sk_err;
`endif

    // Immediate type: opcode decode and explicit select are both formed; AUTO_SEL picks one.
    always_comb begin
        auto_type = T_R;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: auto_type = T_I;
            7'b0100011:                         auto_type = T_S;
            7'b1100011:                         auto_type = T_B;
            7'b1101111:                         auto_type = T_J;
            7'b0110111, 7'b0010111:             auto_type = T_U;
            7'b1110011:                         auto_type = in_instr[14] ? T_Z : T_I;
            default:                            auto_type = T_R;
        endcase

        man_type = T_R;
        case (in_sel)
            3'b000:  man_type = T_I;
            3'b001:  man_type = T_S;
            3'b010:  man_type = T_B;
            3'b011:  man_type = T_J;
            3'b100:  man_type = T_U;
            3'b101:  man_type = T_Z;
            default: man_type = T_R;
        endcase

        sel_type = (AUTO_SEL != 0) ? auto_type : man_type;
    end

    // Extraction to a 32-bit value whose bit 31 is the extension bit; Z keeps bit 31 clear.
    always_comb begin
        imm32   = 32'd0;
        new_err = 1'b0;
        case (sel_type)
            T_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            T_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
            T_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
            T_U: imm32 = {in_instr[31:12], 12'd0};
            T_Z: imm32 = {27'd0, in_instr[19:15]};
            default: begin
                imm32   = 32'd0;
                new_err = 1'b1;
            end
        endcase
        new_imm = XLEN'($signed(imm32));
    end

    // Skid full is the only reason to refuse input, so in_ready is purely registered.
    assign in_ready  = !sk_valid;
    assign out_valid = or_valid;
    assign out_imm   = or_imm;
    assign out_tag   = or_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
    assign out_err   = or_err;
`endif

    // Output register: refilled from skid first (FIFO order), else from the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_valid <= 1'b0;
            or_imm   <= '0;
            or_tag   <= '0;
`ifdef IMM_GEN_PIPE_ERR_EN
            or_err   <= 1'b0;
`endif
        end else if (flush) begin
            or_valid <= 1'b0;
        end else if (!or_valid || out_ready) begin
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_imm   <= sk_imm;
                or_tag   <= sk_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
                or_err   <= sk_err;
`endif
            end else begin
                or_valid <= in_valid;
                if (in_valid) begin
                    or_imm <= new_imm;
                    or_tag <= in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
                    or_err <= new_err;
`endif
                end
            end
        end
    end

    // Skid register: catches an input while OR is stalled, empties when OR drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_valid <= 1'b0;
            sk_imm   <= '0;
            sk_tag   <= '0;
`ifdef IMM_GEN_PIPE_ERR_EN
            sk_err   <= 1'b0;
`endif
        end else if (flush) begin
            sk_valid <= 1'b0;
        end else if (or_valid && !out_ready) begin
            if (!sk_valid && in_valid) begin
                sk_valid <= 1'b1;
                sk_imm   <= new_imm;
                sk_tag   <= in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
                sk_err   <= new_err;
`endif
            end
        end else begin
            sk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: two instances (XLEN=32 with explicit select,
// XLEN=64 with opcode auto-select) driven by the same stream, checked against
// a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;
`ifdef IMM_GEN_PIPE_ERR_EN
    logic        out_err32, out_err64;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [7:0]  tag;
        logic        err32;
        logic        err64;
    } exp_t;
    exp_t q[$];

    logic [6:0] ops [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0101011};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_SEL(0)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32),
`ifdef IMM_GEN_PIPE_ERR_EN
        .out_err(out_err32),
`endif
        .out_tag(out_tag32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .AUTO_SEL(1)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64),
`ifdef IMM_GEN_PIPE_ERR_EN
        .out_err(out_err64),
`endif
        .out_tag(out_tag64));

    // Type from opcode: 0..5 = I,S,B,J,U,Z; 6 = reserved.
    function automatic int auto_type(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 0;
            7'b0100011:                         return 1;
            7'b1100011:                         return 2;
            7'b1101111:                         return 3;
            7'b0110111, 7'b0010111:             return 4;
            7'b1110011:                         return i[14] ? 5 : 0;
            default:                            return 6;
        endcase
    endfunction

    // Immediate value as a 64-bit signed integer, built with shifts on the whole word.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input int t);
        longint s;
        s = longint'($signed(i));
        case (t)
            0: return s >>> 20;
            1: return ((s >>> 25) <<< 5) | longint'(i[11:7]);
            2: return ((s >>> 31) <<< 12) | (longint'(i[7]) << 11)
                      | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            3: return ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12)
                      | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            4: return s & ~longint'(64'hFFF);
            5: return longint'(i[19:15]);
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Compare both instances with the model's current occupancy.
    task automatic check_state();
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_imm32", 64'(out_imm32), 64'(q[0].imm32));
            chk("out_imm64", out_imm64, q[0].imm64);
            chk("out_tag32", 64'(out_tag32), 64'(q[0].tag));
            chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
`ifdef IMM_GEN_PIPE_ERR_EN
            chk("out_err32", 64'(out_err32), 64'(q[0].err32));
            chk("out_err64", 64'(out_err64), 64'(q[0].err64));
`endif
        end
    endtask

    // One clock: drive, check current state, clock, advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] s,
                        input logic [7:0] t, input logic ordy, input logic fl);
        exp_t e;
        logic [63:0] x;
        logic acc;
        in_valid  = v;
        in_instr  = ins;
        in_sel    = s;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        check_state();
        acc = v && (q.size() < 2);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (acc) begin
                x       = ref_imm(ins, int'(s));
                e.imm32 = x[31:0];
                e.imm64 = ref_imm(ins, auto_type(ins));
                e.tag   = t;
                e.err32 = (s >= 3'd6);
                e.err64 = (auto_type(ins) == 6);
                q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_sel = '0; in_tag = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_imm32", 64'(out_imm32), 64'd0);
        chk("rst_tag32", 64'(out_tag32), 64'd0);

        // I-type, both paths decode as I (opcode 0010011)
        step(1, 32'hFFF00093, 3'b000, 8'h11, 1, 0);
        chk("i_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
        chk("i_tag32", 64'(out_tag32), 64'h11);
        chk("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        // B-type, auto-select path
        step(1, 32'hFE000EE3, 3'b010, 8'h22, 1, 0);
        chk("b_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
        chk("b_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);

        // U-type
        step(1, 32'h123450B7, 3'b100, 8'h33, 1, 0);
        chk("u_imm32", 64'(out_imm32), 64'h1234_5000);
        chk("u_imm64", out_imm64, 64'h1234_5000);
        step(1, 32'h800000B7, 3'b100, 8'h34, 1, 0);
        chk("u_neg_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);

        // Z-type (CSRRWI-style encoding with instr[14]=1)
        step(1, 32'h000FD073, 3'b101, 8'h44, 1, 0);
        chk("z_imm32", 64'(out_imm32), 64'h1F);
        chk("z_imm64", out_imm64, 64'h1F);

        // Reserved select on the 32-bit instance
        step(1, 32'hFFFFFFFF, 3'b111, 8'h55, 1, 0);
        chk("rsv_imm32", 64'(out_imm32), 64'd0);
`ifdef IMM_GEN_PIPE_ERR_EN
        chk("rsv_err32", 64'(out_err32), 64'd1);
`endif
        step(0, 32'h0, 3'b000, 8'h00, 1, 0);

        // Backpressure: A, B accepted, C held until space frees up
        step(1, 32'h00100093, 3'b000, 8'hA0, 0, 0);
        step(1, 32'h00200093, 3'b000, 8'hB0, 0, 0);
        chk("bp_in_ready", 64'(in_ready32), 64'd0);
        step(1, 32'h00300093, 3'b000, 8'hC0, 0, 0);
        step(1, 32'h00300093, 3'b000, 8'hC0, 0, 0);
        step(1, 32'h00300093, 3'b000, 8'hC0, 1, 0);
        chk("bp_tag_b", 64'(out_tag32), 64'hB0);
        step(1, 32'h00300093, 3'b000, 8'hC0, 1, 0);
        step(0, 32'h0, 3'b000, 8'h00, 1, 0);
        step(0, 32'h0, 3'b000, 8'h00, 1, 0);

        // Flush with both entries full and a concurrent input
        step(1, 32'h00500093, 3'b000, 8'hD0, 0, 0);
        step(1, 32'h00600093, 3'b000, 8'hD1, 0, 0);
        step(1, 32'h00700093, 3'b000, 8'hD2, 1, 1);
        chk("fl_valid", 64'(out_valid32), 64'd0);
        chk("fl_ready", 64'(in_ready32), 64'd1);
        step(0, 32'h0, 3'b000, 8'h00, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
            step(($urandom_range(0, 3) != 0), ins, 3'($urandom_range(0, 7)),
                 8'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset with both entries full
        step(1, 32'h00800093, 3'b000, 8'hE0, 0, 0);
        step(1, 32'h00900093, 3'b000, 8'hE1, 0, 0);
        check_state();
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk("arst_valid32", 64'(out_valid32), 64'd0);
        chk("arst_valid64", 64'(out_valid64), 64'd0);
        chk("arst_ready32", 64'(in_ready32), 64'd1);
        chk("arst_imm32", 64'(out_imm32), 64'd0);
        chk("arst_imm64", out_imm64, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 32'h00A00093, 3'b000, 8'hF0, 1, 0);
        step(0, 32'h0, 3'b000, 8'h00, 1, 0);
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
